// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock monitor.
// Optional input synchronizer is selected with the CLK_MON_SYNC_EN macro.
package clk_div_pkg;

    localparam int unsigned CNT_W_DEF    = 8;
    localparam int unsigned LOCK_CNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } mon_state_e;

    // All-ones value of a counter of the given width.
    function automatic int unsigned cnt_sat(input int unsigned w);
        return (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_edge_det.sv
// Input register and edge detector for the monitored signal.
// CLK_MON_SYNC_EN adds a two-flop synchronizer ahead of the input register.
module clk_edge_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o,
    output logic fall_o,
    output logic level_o
);

    logic s_in;
    logic s_q;
    logic s_prev_q;
    logic rise_q;
    logic fall_q;

`ifdef CLK_MON_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], sig_i};
        end
    end

    assign s_in = sync_q[1];
`else
    assign s_in = sig_i;
`endif

    // Edges are registered so that level_o (s_prev_q) lines up with them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_q      <= 1'b0;
            s_prev_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            s_q      <= s_in;
            s_prev_q <= s_q;
            rise_q   <= s_q & ~s_prev_q;
            fall_q   <= ~s_q & s_prev_q;
        end
    end

    assign rise_o  = rise_q;
    assign fall_o  = fall_q;
    assign level_o = s_prev_q;

endmodule

// File: rtl/clk_div_monitor.sv
// Period / high-time checker for a divided clock sampled in the clk domain.
// Build option: CLK_MON_SYNC_EN (input synchronizer inside clk_edge_det).
module clk_div_monitor
    import clk_div_pkg::*;
#(
    parameter int unsigned CNT_W    = CNT_W_DEF,
    parameter int unsigned LOCK_CNT = LOCK_CNT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sig_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             err,
    output logic             timeout,
    output logic             locked
);

    localparam int unsigned      MW     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] SAT    = CNT_W'(cnt_sat(CNT_W));
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [MW-1:0]    LOCK_V = MW'(LOCK_CNT);

    logic rise;
    logic fall;
    logic level;

    clk_edge_det u_edge (
        .clk_i   (clk),
        .rst_i   (rst),
        .sig_i   (sig_in),
        .rise_o  (rise),
        .fall_o  (fall),
        .level_o (level)
    );

    mon_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [MW-1:0]    match_q, match_d;
    logic             mv_q, mv_d;
    logic             err_q, err_d;
    logic             to_q, to_d;
    logic             locked_q, locked_d;
    logic [MW-1:0]    match_inc;

    assign match_inc = (match_q == LOCK_V) ? match_q : match_q + MW'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        period_d = period_q;
        high_d   = high_q;
        match_d  = match_q;
        mv_d     = 1'b0;
        err_d    = 1'b0;
        to_d     = 1'b0;
        locked_d = locked_q;

        if (!en) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            hcnt_d   = '0;
            match_d  = '0;
            locked_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ACQUIRE;
                    cnt_d   = '0;
                    hcnt_d  = '0;
                end
                ST_ACQUIRE: begin
                    if (rise) begin
                        state_d = ST_TRACK;
                        cnt_d   = ONE;
                        hcnt_d  = ONE;
                    end
                end
                ST_TRACK: begin
                    if (rise) begin
                        period_d = cnt_q;
                        mv_d     = 1'b1;
                        cnt_d    = ONE;
                        hcnt_d   = ONE;
                        if (cnt_q != exp_period) begin
                            err_d    = 1'b1;
                            match_d  = '0;
                            locked_d = 1'b0;
                        end else begin
                            match_d  = match_inc;
                            locked_d = (match_inc == LOCK_V);
                        end
                    end else begin
                        if (cnt_q != SAT) begin
                            cnt_d = cnt_q + ONE;
                        end
                        if (level && (hcnt_q != SAT)) begin
                            hcnt_d = hcnt_q + ONE;
                        end
                        if (fall) begin
                            high_d = hcnt_q;
                        end
                        // A rise in the saturating cycle is handled above and wins.
                        if (cnt_q == SAT) begin
                            to_d     = 1'b1;
                            match_d  = '0;
                            locked_d = 1'b0;
                            state_d  = ST_ACQUIRE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            hcnt_q   <= '0;
            period_q <= '0;
            high_q   <= '0;
            match_q  <= '0;
            mv_q     <= 1'b0;
            err_q    <= 1'b0;
            to_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hcnt_q   <= hcnt_d;
            period_q <= period_d;
            high_q   <= high_d;
            match_q  <= match_d;
            mv_q     <= mv_d;
            err_q    <= err_d;
            to_q     <= to_d;
            locked_q <= locked_d;
        end
    end

    assign period     = period_q;
    assign high_time  = high_q;
    assign meas_valid = mv_q;
    assign err        = err_q;
    assign timeout    = to_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: vector table, directed corner sequences and
// randomized stimulus against a timestamp-based reference model.
module tb_clk_div_monitor;

    localparam int CW   = 8;
    localparam int LK   = 4;
    localparam int SATV = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] exp_period = '0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          meas_valid;
    logic          err;
    logic          timeout;
    logic          locked;

    always #5 clk = ~clk;

    clk_div_monitor #(.CNT_W(CW), .LOCK_CNT(LK)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sig_in     (sig_in),
        .exp_period (exp_period),
        .period     (period),
        .high_time  (high_time),
        .meas_valid (meas_valid),
        .err        (err),
        .timeout    (timeout),
        .locked     (locked)
    );

    int vectors = 0;
    int miscompares = 0;
    int gstep = 0;
    int ph = 0;

    // Reference model: rises/falls seen by the capture stage are the input
    // samples two and three edges back; periods are rise timestamp differences.
    int  edge_n;
    bit  smp[$];
    int  mode;        // 0 disabled, 1 waiting for first rise, 2 tracking
    int  t_last;
    int  run_len;
    bit  m_mv, m_err, m_to, m_lk;
    int  m_per, m_ht;

    task automatic model_reset();
        edge_n = 0;
        smp.delete();
        for (int i = 0; i < 4; i++) smp.push_back(1'b0);
        mode = 0; t_last = 0; run_len = 0;
        m_mv = 0; m_err = 0; m_to = 0; m_lk = 0; m_per = 0; m_ht = 0;
    endtask

    task automatic model_edge(input bit e, input bit x);
        bit r, f;
        edge_n++;
        smp.push_front(x);
        void'(smp.pop_back());
        r = smp[2] & !smp[3];
        f = !smp[2] & smp[3];
        m_mv = 0; m_err = 0; m_to = 0;
        if (!e) begin
            mode = 0; m_lk = 0; run_len = 0;
        end else if (mode == 0) begin
            mode = 1;
        end else if (mode == 1) begin
            if (r) begin mode = 2; t_last = edge_n; end
        end else begin
            if (r) begin
                m_per = edge_n - t_last;
                m_mv = 1;
                if (m_per != int'(exp_period)) begin m_err = 1; run_len = 0; end
                else run_len++;
                m_lk = (run_len >= LK);
                t_last = edge_n;
            end else begin
                if (f) m_ht = edge_n - t_last;
                if (edge_n - t_last >= SATV) begin
                    m_to = 1; m_lk = 0; run_len = 0; mode = 1;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input bit mv, input bit er, input bit to,
                       input bit lk, input int per, input int ht);
        vectors++;
        if (meas_valid !== mv || err !== er || timeout !== to || locked !== lk ||
            period !== CW'(per) || high_time !== CW'(ht)) begin
            miscompares++;
            $display("FAIL %s step %0d: got mv=%0b err=%0b to=%0b lk=%0b per=%0d ht=%0d, want mv=%0b err=%0b to=%0b lk=%0b per=%0d ht=%0d",
                     nm, gstep, meas_valid, err, timeout, locked, period, high_time,
                     mv, er, to, lk, per, ht);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s step %0d: got %0d, want %0d", nm, gstep, got, want);
        end
    endtask

    task automatic step(input bit e, input bit x, input bit do_chk);
        en = e;
        sig_in = x;
        @(posedge clk);
        #1;
        gstep++;
        model_edge(e, x);
        if (do_chk) chk("model", m_mv, m_err, m_to, m_lk, m_per, m_ht);
    endtask

    task automatic run_div(input bit e, input int p, input int n);
        ph = ph % p;
        for (int i = 0; i < n; i++) begin
            step(e, (ph < p / 2), 1'b1);
            ph = (ph + 1) % p;
        end
    endtask

    task automatic set_exp(input int v);
        step(1'b0, sig_in, 1'b1);
        exp_period = CW'(v);
        step(1'b0, sig_in, 1'b1);
    endtask

    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("async_rst", 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        bit en;
        bit sig;
        bit mv;
        bit lk;
        int per;
        int ht;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int cnt, last_mv, errs;
        bit seen;

        // div2 from reset, exp_period=2; row i is the state after edge i+1.
        tbl[0]  = '{1, 1, 0, 0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 1, 0, 0, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 1};
        tbl[4]  = '{1, 1, 1, 0, 2, 1};
        tbl[5]  = '{1, 0, 0, 0, 2, 1};
        tbl[6]  = '{1, 1, 1, 0, 2, 1};
        tbl[7]  = '{1, 0, 0, 0, 2, 1};
        tbl[8]  = '{1, 1, 1, 0, 2, 1};
        tbl[9]  = '{1, 0, 0, 0, 2, 1};
        tbl[10] = '{1, 1, 1, 1, 2, 1};
        tbl[11] = '{1, 0, 0, 1, 2, 1};

        exp_period = CW'(2);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            step(tbl[i].en, tbl[i].sig, 1'b0);
            chk($sformatf("table%0d", i), tbl[i].mv, 1'b0, 1'b0, tbl[i].lk,
                tbl[i].per, tbl[i].ht);
        end

        // div16 lock
        set_exp(16);
        ph = 0; cnt = 0; last_mv = 0;
        for (int i = 0; i < 200 && cnt < 4; i++) begin
            run_div(1'b1, 16, 1);
            if (meas_valid) begin
                cnt++;
                last_mv = gstep;
                if (cnt < 4) check_int("div16_prelock", int'(locked), 0);
                else chk("div16_lock", 1, 0, 0, 1, 16, 8);
            end
        end
        check_int("div16_mv_count", cnt, 4);

        // stuck low -> timeout 255 cycles after the last measurement
        seen = 0;
        for (int i = 0; i < 400; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (meas_valid) last_mv = gstep;
            if (timeout) begin seen = 1; break; end
        end
        check_int("timeout_seen", int'(seen), 1);
        if (seen) check_int("timeout_gap", gstep - last_mv, SATV);
        check_int("timeout_unlock", int'(locked), 0);
        ph = 0; cnt = 0;
        for (int i = 0; i < 18; i++) begin
            run_div(1'b1, 16, 1);
            if (meas_valid) cnt++;
        end
        check_int("acquire_no_mv", cnt, 0);
        run_div(1'b1, 16, 40);

        // lock at div8, then drop enable mid-period
        set_exp(8);
        ph = 0;
        run_div(1'b1, 8, 60);
        check_int("div8_lock", int'(locked), 1);
        run_div(1'b1, 8, 3);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            run_div(1'b0, 8, 1);
            if (meas_valid || err || timeout) cnt++;
        end
        check_int("disabled_pulses", cnt, 0);
        check_int("disabled_unlock", int'(locked), 0);
        check_int("disabled_period", int'(period), 8);
        run_div(1'b1, 8, 60);

        // switch to div4 while expecting 8, then re-lock with exp 4
        errs = 0;
        for (int i = 0; i < 40; i++) begin
            run_div(1'b1, 4, 1);
            if (err) begin
                errs++;
                check_int("err_drops_lock", int'(locked), 0);
            end
        end
        check_int("div4_err_seen", int'(errs > 0), 1);
        set_exp(4);
        run_div(1'b1, 4, 40);
        check_int("div4_relock", int'(locked), 1);

        // asynchronous reset mid-period
        run_div(1'b1, 4, 2);
        async_reset();
        run_div(1'b1, 8, 30);

        // randomized segments
        for (int s = 0; s < 40; s++) begin
            int k;
            int p;
            bit lv;
            k = $urandom_range(0, 6);
            case (k)
                0: run_div(1'b1, 2 << $urandom_range(0, 3), $urandom_range(30, 150));
                1, 2: begin
                    p = $urandom_range(2, 24);
                    run_div(1'b1, p, $urandom_range(30, 150));
                end
                3: begin
                    lv = 1'($urandom_range(0, 1));
                    for (int i = 0; i < int'($urandom_range(240, 300)); i++)
                        step(1'b1, lv, 1'b1);
                end
                4: begin
                    if ($urandom_range(0, 1) == 0)
                        set_exp(2 << $urandom_range(0, 3));
                    else
                        set_exp($urandom_range(2, 24));
                    for (int i = 0; i < int'($urandom_range(0, 5)); i++)
                        step(1'b0, 1'($urandom_range(0, 1)), 1'b1);
                end
                5: for (int i = 0; i < 20; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1);
                default: if ($urandom_range(0, 3) == 0) async_reset();
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
